// File: rtl/serial_sram_top_if.sv
// serial_sram_top_if: serial load, word access and read-response signals of the serial SRAM block.
interface serial_sram_top_if #(
  parameter int ROWS = 16,
  parameter int COLS = 8
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  logic serial_in;
  logic shift;
  logic load;
  logic w_en;
  logic r_en;
  logic [AW-1:0] addr;
  logic data_valid;
  logic [COLS-1:0] data_out;
  logic parity_err;
  modport master (
    output serial_in, shift, load, w_en, r_en, addr,
    input  data_valid, data_out, parity_err
  );
  modport slave (
    input  serial_in, shift, load, w_en, r_en, addr,
    output data_valid, data_out, parity_err
  );
endinterface

// File: rtl/serial_sram_top.sv
// serial_sram_top: serially loaded ROWS x COLS register-array SRAM with a one-cycle registered read.
// Define SRAM_PARITY_EN to store a per-row even-parity bit and flag mismatches on read.
module serial_sram_top #(
  parameter int ROWS = 16,
  parameter int COLS = 8
) (
  input logic clk,
  input logic arst_n,
  serial_sram_top_if.slave bus
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  logic [COLS-1:0] sreg;
  logic [COLS-1:0] pword;
  logic [COLS-1:0] data_q;
  logic [COLS-1:0] rd_word;
  logic [AW-1:0] addr_q;
  logic vld_q;
  logic in_range;
  logic rd;
  logic [COLS-1:0] mem [ROWS];
  assign in_range = 32'(bus.addr) < ROWS;
  assign rd = bus.r_en & ~bus.w_en;
  assign rd_word = in_range ? mem[bus.addr] : '0;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sreg <= '0;
      pword <= '0;
    end else begin
      if (bus.shift) sreg <= {sreg[COLS-2:0], bus.serial_in};
      if (bus.load) pword <= sreg;
    end
  end
  // Storage is deliberately left out of reset so contents survive an arst_n pulse.
  always_ff @(posedge clk) begin
    if (bus.w_en && in_range) mem[bus.addr] <= pword;
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      data_q <= '0;
      addr_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= rd;
      if (rd) begin
        data_q <= rd_word;
        addr_q <= bus.addr;
      end
    end
  end
  assign bus.data_out = data_q;
  // Valid only while the same read is still being requested, so data_out always matches mem[addr].
  assign bus.data_valid = vld_q & rd & (bus.addr == addr_q);
`ifdef SRAM_PARITY_EN
  logic par_mem [ROWS];
  logic rd_par;
  logic perr_q;
  assign rd_par = in_range ? par_mem[bus.addr] : 1'b0;
  always_ff @(posedge clk) begin
    if (bus.w_en && in_range) par_mem[bus.addr] <= ^pword;
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) perr_q <= 1'b0;
    else if (rd) perr_q <= (^rd_word) ^ rd_par;
  end
  assign bus.parity_err = bus.data_valid & perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial_sram_top.sv
// tb_serial_sram_top: table-driven write/read sweep plus hand-written corner sequences, scoreboard-checked.
module tb_serial_sram_top;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;
  serial_sram_top_if #(.ROWS(16), .COLS(8)) bus ();
  serial_sram_top #(.ROWS(16), .COLS(8)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));
  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } vec_t;
  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic perr;
  } exp_t;
  vec_t vt[16];
  exp_t sb[$];
  logic [7:0] model [16];
  int n_vec = 0;
  int n_fail = 0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic shift_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      bus.serial_in = w[i];
      bus.shift = 1'b1;
      tick();
    end
    bus.shift = 1'b0;
    bus.serial_in = 1'b0;
  endtask
  task automatic load_word();
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask
  task automatic write_word(input logic [3:0] a, input logic [7:0] d);
    shift_word(d);
    load_word();
    bus.addr = a;
    bus.w_en = 1'b1;
    tick();
    bus.w_en = 1'b0;
    model[a] = d;
  endtask
  task automatic do_read(input logic [3:0] a, input logic perr);
    exp_t e;
    logic got;
    sb.push_back('{a, model[a], perr});
    bus.addr = a;
    bus.r_en = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      tick();
      got = bus.data_valid;
    end
    e = sb.pop_front();
    if (!got) begin
      n_vec++;
      n_fail++;
      $display("FAIL read_timeout addr %0d: data_valid never rose", e.addr);
    end else begin
      chk($sformatf("read_data[%0d]", e.addr), 32'(bus.data_out), 32'(e.data));
      chk($sformatf("read_perr[%0d]", e.addr), 32'(bus.parity_err), 32'(e.perr));
    end
    tick();
    bus.r_en = 1'b0;
    #1;
    chk("valid_drop_on_r_en_low", 32'(bus.data_valid), 32'd0);
  endtask
  initial begin
    bus.serial_in = 1'b0;
    bus.shift = 1'b0;
    bus.load = 1'b0;
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    bus.addr = '0;
    for (int i = 0; i < 16; i++) vt[i] = '{4'(i), 8'(i * 17)};
    repeat (2) tick();
    chk("reset_data_out", 32'(bus.data_out), 32'd0);
    chk("reset_data_valid", 32'(bus.data_valid), 32'd0);
    chk("reset_parity_err", 32'(bus.parity_err), 32'd0);
    arst_n = 1'b1;
    tick();
    chk("reset_pword", 32'(dut.pword), 32'd0);
    shift_word(8'hA5);
    load_word();
    chk("sipo_a5", 32'(dut.pword), 32'hA5);
    shift_word(8'h3C);
    bus.serial_in = 1'b1;
    bus.shift = 1'b1;
    bus.load = 1'b1;
    tick();
    bus.shift = 1'b0;
    bus.load = 1'b0;
    bus.serial_in = 1'b0;
    chk("sipo_load_pre_shift", 32'(dut.pword), 32'h3C);
    chk("sipo_shift_during_load", 32'(dut.sreg), 32'h79);
    for (int i = 0; i < 16; i++) write_word(vt[i].addr, vt[i].data);
    for (int i = 0; i < 16; i++) do_read(vt[i].addr, 1'b0);
    write_word(4'd7, 8'h5A);
    do_read(4'd7, 1'b0);
    write_word(4'd7, 8'hC3);
    do_read(4'd7, 1'b0);
    shift_word(8'h96);
    load_word();
    bus.addr = 4'd5;
    bus.w_en = 1'b1;
    bus.r_en = 1'b1;
    #1;
    chk("collision_valid_low", 32'(bus.data_valid), 32'd0);
    tick();
    bus.w_en = 1'b0;
    model[5] = 8'h96;
    #1;
    chk("collision_vld_cleared", 32'(bus.data_valid), 32'd0);
    tick();
    chk("collision_read_valid", 32'(bus.data_valid), 32'd1);
    chk("collision_write_done", 32'(bus.data_out), 32'h96);
    bus.r_en = 1'b0;
    bus.addr = 4'd2;
    bus.r_en = 1'b1;
    tick();
    chk("step_valid_a2", 32'(bus.data_valid), 32'd1);
    chk("step_data_a2", 32'(bus.data_out), 32'(model[2]));
    bus.addr = 4'd3;
    #1;
    chk("step_valid_drop", 32'(bus.data_valid), 32'd0);
    tick();
    chk("step_valid_a3", 32'(bus.data_valid), 32'd1);
    chk("step_data_a3", 32'(bus.data_out), 32'(model[3]));
    bus.r_en = 1'b0;
    bus.addr = 4'd6;
    bus.r_en = 1'b1;
    tick();
    chk("midreset_valid_before", 32'(bus.data_valid), 32'd1);
    arst_n = 1'b0;
    #1;
    chk("midreset_valid_drop", 32'(bus.data_valid), 32'd0);
    chk("midreset_data_clr", 32'(bus.data_out), 32'd0);
    tick();
    bus.r_en = 1'b0;
    arst_n = 1'b1;
    tick();
    do_read(4'd6, 1'b0);
`ifdef SRAM_PARITY_EN
    dut.mem[4] = dut.mem[4] ^ 8'h01;
    model[4] = model[4] ^ 8'h01;
    do_read(4'd4, 1'b1);
    do_read(4'd5, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
